// File: rtl/register_file.sv
// Register file: R0-R14 stored, R15 reads back as {24'b0, PC}, BL link write into R14.
// Define RF_BYPASS_EN to forward a pending write to the combinational read ports.
module register_file (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  RA,
    input  logic [3:0]  RB,
    input  logic [3:0]  RD,
    output logic [31:0] PA,
    output logic [31:0] PB,
    output logic [31:0] PD,
    input  logic [3:0]  RW,
    input  logic [31:0] PW,
    input  logic        LE,
    input  logic [7:0]  PC,
    input  logic        BL_LE,
    input  logic [7:0]  LR_D,
    output logic        WR15_ERR
);

    logic [31:0]       link_val;
    logic [15:0][31:0] reg_bus;
    logic [2:0][3:0]   rd_addr;
    logic [2:0][31:0]  rd_data;
    logic              wr15_err_reg;

    assign link_val    = {24'h0, LR_D};
    assign reg_bus[15] = {24'h0, PC};

    genvar gi;
    generate
        // The link write takes priority over write-back when both target R14.
        for (gi = 0; gi < 15; gi++) begin : g_reg
            localparam logic [3:0] IDX = 4'(gi);
            logic [31:0] data_reg;
            logic        link_sel;
            logic        wb_sel;

            assign link_sel = BL_LE && (IDX == 4'd14);
            assign wb_sel   = LE && (RW == IDX);

            always_ff @(posedge Clk or posedge Clr) begin
                if (Clr) begin
                    data_reg <= '0;
                end else if (link_sel) begin
                    data_reg <= link_val;
                end else if (wb_sel) begin
                    data_reg <= PW;
                end
            end

            assign reg_bus[gi] = data_reg;
        end
    endgenerate

    assign rd_addr = {RD, RB, RA};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            logic [31:0] val;
`ifdef RF_BYPASS_EN
            // No write is pending while Clr holds the array cleared.
            always_comb begin
                val = reg_bus[rd_addr[gi]];
                if (!Clr && (rd_addr[gi] != 4'd15)) begin
                    if (BL_LE && (rd_addr[gi] == 4'd14)) begin
                        val = link_val;
                    end else if (LE && (RW == rd_addr[gi])) begin
                        val = PW;
                    end
                end
            end
`else
            assign val = reg_bus[rd_addr[gi]];
`endif
            assign rd_data[gi] = val;
        end
    endgenerate

    assign PA = rd_data[0];
    assign PB = rd_data[1];
    assign PD = rd_data[2];

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            wr15_err_reg <= 1'b0;
        end else if (LE && (RW == 4'd15)) begin
            wr15_err_reg <= 1'b1;
        end
    end

    assign WR15_ERR = wr15_err_reg;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file; expected values queued at drive time, popped at sample time.
module tb_register_file;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [3:0]  RA, RB, RD, RW;
    logic [31:0] PA, PB, PD, PW;
    logic        LE, BL_LE, WR15_ERR;
    logic [7:0]  PC, LR_D;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [0:14];

    register_file dut (
        .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RD(RD),
        .PA(PA), .PB(PB), .PD(PD), .RW(RW), .PW(PW), .LE(LE),
        .PC(PC), .BL_LE(BL_LE), .LR_D(LR_D), .WR15_ERR(WR15_ERR)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t mk(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        Clr = 1'b1; LE = 0; BL_LE = 0; RW = 0; PW = 0; LR_D = 0; PC = 0;
        RA = 0; RB = 0; RD = 0;
        repeat (2) @(posedge Clk);
        #1;
        sb.push_back(mk("rst_err_during_clr", 32'h0));
        e = sb.pop_front(); n_vec++;
        if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
        @(negedge Clk);
        Clr = 1'b0; RA = 4'd3; RB = 4'd14; RD = 4'd15; PC = 8'h2C;
        sb.push_back(mk("rst_pa_r3", 32'h0));
        sb.push_back(mk("rst_pb_r14", 32'h0));
        sb.push_back(mk("rst_pd_r15", 32'h0000002C));
        sb.push_back(mk("rst_err", 32'h0));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
        e = sb.pop_front(); n_vec++;
        if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
        for (int i = 0; i < 15; i++) begin
            mdl[i] = 32'h0;
            @(negedge Clk);
            RA = 4'(i);
            sb.push_back(mk($sformatf("rst_zero_r%0d", i), 32'h0));
            #1;
            e = sb.pop_front(); n_vec++;
            if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        end
        $display("reset: all registers read zero after Clr");
    endtask

    task automatic test_write();
        exp_t e;
        @(negedge Clk);
        LE = 1; RW = 4'd5; PW = 32'hDEADBEEF; RA = 4'd5;
        @(posedge Clk);
        mdl[5] = 32'hDEADBEEF;
        sb.push_back(mk("wr_r5", 32'hDEADBEEF));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        @(negedge Clk);
        LE = 0; PW = 32'h0;
        @(posedge Clk);
        sb.push_back(mk("wr_r5_hold", 32'hDEADBEEF));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        $display("write: R5 <= DEADBEEF, held with LE=0");
    endtask

    task automatic test_all_regs();
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            LE = 1; RW = 4'(i); PW = $urandom;
            mdl[i] = PW;
            @(posedge Clk);
        end
        @(negedge Clk);
        LE = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            RA = 4'(i); RB = 4'(14 - i); RD = 4'((i + 1) % 15);
            sb.push_back(mk($sformatf("all_pa_r%0d", i), mdl[i]));
            sb.push_back(mk($sformatf("all_pb_r%0d", 14 - i), mdl[14 - i]));
            sb.push_back(mk($sformatf("all_pd_r%0d", (i + 1) % 15), mdl[(i + 1) % 15]));
            #1;
            e = sb.pop_front(); n_vec++;
            if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
            e = sb.pop_front(); n_vec++;
            if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
            e = sb.pop_front(); n_vec++;
            if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
            $display("all_regs: read R%0d/R%0d/R%0d", i, 14 - i, (i + 1) % 15);
        end
    endtask

    task automatic test_link();
        exp_t e;
        @(negedge Clk);
        LE = 1; RW = 4'd14; PW = 32'h11111111; BL_LE = 1; LR_D = 8'h40; RA = 4'd14;
        @(posedge Clk);
        mdl[14] = 32'h00000040;
        sb.push_back(mk("link_wins_r14", mdl[14]));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        @(negedge Clk);
        LE = 1; RW = 4'd3; PW = 32'hCAFEF00D; BL_LE = 1; LR_D = 8'h88; RA = 4'd3; RB = 4'd14;
        @(posedge Clk);
        mdl[3] = 32'hCAFEF00D; mdl[14] = 32'h00000088;
        sb.push_back(mk("dual_r3", mdl[3]));
        sb.push_back(mk("dual_r14", mdl[14]));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
        @(negedge Clk);
        LE = 0; BL_LE = 0;
        $display("link: R14 conflict and dual write checked");
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic [31:0] pend;
        @(negedge Clk);
        LE = 1; RW = 4'd7; PW = 32'h12345678; RA = 4'd7; RB = 4'd7; RD = 4'd7;
`ifdef RF_BYPASS_EN
        pend = 32'h12345678;
`else
        pend = mdl[7];
`endif
        sb.push_back(mk("byp_pa", pend));
        sb.push_back(mk("byp_pb", pend));
        sb.push_back(mk("byp_pd", pend));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
        @(posedge Clk);
        mdl[7] = 32'h12345678;
        sb.push_back(mk("byp_after_edge", mdl[7]));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
        @(negedge Clk);
        LE = 1; RW = 4'd14; PW = 32'h99999999; BL_LE = 1; LR_D = 8'h5A; RA = 4'd14;
`ifdef RF_BYPASS_EN
        pend = 32'h0000005A;
`else
        pend = mdl[14];
`endif
        sb.push_back(mk("byp_link_r14", pend));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        @(posedge Clk);
        mdl[14] = 32'h0000005A;
        @(negedge Clk);
        LE = 0; BL_LE = 0;
        $display("bypass: pending-write reads checked");
    endtask

    task automatic test_r15();
        exp_t e;
        @(negedge Clk);
        LE = 1; RW = 4'd15; PW = 32'hFFFFFFFF; PC = 8'h6E; RD = 4'd15; RA = 4'd5;
        sb.push_back(mk("r15_err_before", 32'h0));
        sb.push_back(mk("r15_pending_read", 32'h0000006E));
        #1;
        e = sb.pop_front(); n_vec++;
        if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
        @(posedge Clk);
        sb.push_back(mk("r15_err_set", 32'h1));
        sb.push_back(mk("r15_reads_pc", 32'h0000006E));
        sb.push_back(mk("r15_r5_untouched", mdl[5]));
        #1;
        e = sb.pop_front(); n_vec++;
        if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        @(negedge Clk);
        LE = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            PC = 8'(8'h10 + i);
            sb.push_back(mk($sformatf("r15_sticky_%0d", i), 32'h1));
            sb.push_back(mk($sformatf("r15_pc_%0d", i), {24'h0, 8'(8'h10 + i)}));
            #1;
            e = sb.pop_front(); n_vec++;
            if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
            e = sb.pop_front(); n_vec++;
            if (PD !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PD, e.val); end
        end
        $display("r15: write ignored, WR15_ERR sticky");
    endtask

    task automatic test_async_clear();
        exp_t e;
        @(negedge Clk);
        LE = 1; RW = 4'd2; PW = 32'hA5A5A5A5; RA = 4'd2;
        @(posedge Clk);
        mdl[2] = 32'hA5A5A5A5;
        sb.push_back(mk("clr_r2_loaded", mdl[2]));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        @(negedge Clk);
        PW = 32'h55555555; RB = 4'd7;
        #2;
        Clr = 1'b1;
        for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
        sb.push_back(mk("clr_r2_immediate", 32'h0));
        sb.push_back(mk("clr_err_immediate", 32'h0));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        e = sb.pop_front(); n_vec++;
        if ({31'h0, WR15_ERR} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, WR15_ERR, e.val); end
        @(posedge Clk);
        sb.push_back(mk("clr_no_write_r2", 32'h0));
        sb.push_back(mk("clr_r7", 32'h0));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        e = sb.pop_front(); n_vec++;
        if (PB !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PB, e.val); end
        @(negedge Clk);
        LE = 0; Clr = 1'b0;
        sb.push_back(mk("clr_after_release", mdl[2]));
        #1;
        e = sb.pop_front(); n_vec++;
        if (PA !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, PA, e.val); end
        $display("async_clear: mid-cycle Clr cleared R2 with write blocked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_all_regs();
        test_link();
        test_bypass();
        test_r15();
        test_async_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high; clock port Clk, reset port Clr.
REQ-003 Clk  input  1  rising-edge clock for all register writes.
REQ-004 Clr  input  1  asynchronous active-high clear of all registers.
REQ-005 RA  input  4  read address port A (instruction bits 19:16, Rn).
REQ-006 RB  input  4  read address port B (instruction bits 3:0, Rm).
REQ-007 RD  input  4  read address port D (instruction bits 15:12, store data).
REQ-008 PA  output  32  port A read data.
REQ-009 PB  output  32  port B read data.
REQ-010 PD  output  32  port D read data.
REQ-011 RW  input  4  write-back destination register, from MEM/WB.
REQ-012 PW  input  32  write-back data, from MEM/WB.
REQ-013 LE  input  1  write-back enable (MEM/WB RF_enable).
REQ-014 PC  input  8  current next-PC value from IF/ID.
REQ-015 BL_LE  input  1  link-write enable, asserted for a BL instruction in ID.
REQ-016 LR_D  input  8  link value (return address) for R14.
REQ-017 WR15_ERR  output  1  registered sticky flag: a write to R15 was attempted.

Function
REQ-018 The block holds R0-R14 as 32-bit registers; R15 is not stored.
REQ-019 Reads are combinational: PA, PB and PD are valid in the same cycle as RA, RB and RD.
REQ-020 Reading address 15 on any port returns {24'b0, PC}.
REQ-021 When LE=1 and RW is 0-14, R[RW] takes PW on the rising Clk edge.
REQ-022 When BL_LE=1, R14 takes {24'b0, LR_D} on the rising Clk edge.
REQ-023 When LE=1, RW=14 and BL_LE=1 in the same cycle, the link write wins and PW is discarded.
REQ-024 When LE=1 and RW=15, no register changes; WR15_ERR is set on that edge and stays 1 until Clr.
REQ-025 When LE=1, BL_LE=1 and RW is not 14, both writes happen on the same edge.
REQ-026 When LE=0 and BL_LE=0, the register contents do not change.
REQ-027 Read ports are independent; all three may address the same register in the same cycle.

Reset
REQ-028 While Clr=1, R0-R14 are 0 and WR15_ERR is 0, regardless of Clk.
REQ-029 Clr asserted in the middle of a cycle clears immediately; no write is performed on a clock edge while Clr=1.
REQ-030 After Clr deasserts, PA, PB and PD read 0 for R0-R14 and {24'b0, PC} for R15.

Configuration
REQ-031 Macro RF_BYPASS_EN enables write-through bypass.
REQ-032 With RF_BYPASS_EN defined: in a cycle where a write to register n is pending, a read of n on any port returns that value combinationally.
  - The bypassed value is PW, or {24'b0, LR_D} under REQ-023.
  - R15 reads are never bypassed.
REQ-033 Without RF_BYPASS_EN: reads always return the stored value; the new value is visible only after the edge.

Verification
REQ-034 Clr=1 for 2 cycles, then RA=3, RB=14, RD=15, PC=8'h2C -> PA=0, PB=0, PD=32'h0000002C, WR15_ERR=0.
REQ-035 LE=1, RW=5, PW=32'hDEADBEEF, one edge, then RA=5 -> PA=32'hDEADBEEF; a later edge with LE=0, PW=0 leaves R5 unchanged.
REQ-036 Same cycle: LE=1, RW=14, PW=32'h11111111, BL_LE=1, LR_D=8'h40 -> after edge, R14 reads 32'h00000040.
REQ-037 LE=1, RW=15, PW=32'hFFFFFFFF -> R15 still reads {24'b0, PC}; WR15_ERR=1 after the edge and remains 1 until Clr.
REQ-038 With RF_BYPASS_EN: LE=1, RW=7, PW=32'h12345678, RA=RB=RD=7 before the edge -> all three ports read 32'h12345678; without the macro they read the old R7 until the edge.
REQ-039 R2=32'hA5A5A5A5; assert Clr asynchronously mid-cycle with LE=1, RW=2 -> PA for RA=2 goes to 0 at once, and no write occurs while Clr=1.
